// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed 7-segment scanner with frame-aligned load handshake
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        busy,
    output logic        ack,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      pending;
    logic             tick;
    logic             frame_end;
    logic             blank;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex_font(input logic [3:0] d);
        case (d)
            4'h0: hex_font = 7'b0000001;
            4'h1: hex_font = 7'b1001111;
            4'h2: hex_font = 7'b0010010;
            4'h3: hex_font = 7'b0000110;
            4'h4: hex_font = 7'b1001100;
            4'h5: hex_font = 7'b0100100;
            4'h6: hex_font = 7'b0100000;
            4'h7: hex_font = 7'b0001111;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0000100;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b1100000;
            4'hC: hex_font = 7'b0110001;
            4'hD: hex_font = 7'b1000010;
            4'hE: hex_font = 7'b0110000;
            default: hex_font = 7'b0111000;
        endcase
    endfunction

    assign tick      = en && (cnt == CNT_MAX);
    assign frame_end = tick && (idx == 2'd3);
    assign nibble    = shadow[{idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank only when it and every more-significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (shadow[15:4] == 12'h000);
            2'd2:    blank = (shadow[15:8] == 8'h00);
            2'd3:    blank = (shadow[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= 2'd0;
            shadow  <= 16'h0000;
            pending <= 16'h0000;
            busy    <= 1'b0;
            ack     <= 1'b0;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
        end else begin
            ack <= 1'b0;
            if (en) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    idx <= idx + 2'd1;
                end
            end

            // Commit swaps the shadow only between frames so a digit never tears.
            if (busy) begin
                if (frame_end) begin
                    shadow <= pending;
                    busy   <= 1'b0;
                    ack    <= 1'b1;
                end
            end else if (load) begin
                pending <= data_in;
                busy    <= 1'b1;
            end

            if (!en || blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= hex_font(nibble);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        load = 1'b0;
    logic        busy;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] an_pat [4];
    logic [6:0] seg_12af [4];

    seg_scan_ctrl #(.SCAN_DIV(4), .CNT_W(17)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .data_in(data_in),
        .load(load),
        .busy(busy),
        .ack(ack),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async an=%b seg=%b busy=%b ack=%b want an=1111 seg=1111111 busy=0 ack=0", an, seg, busy, ack);
        end
        step(2);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step(1);
            vectors++;
            if (an !== an_pat[j/4] || seg !== 7'b0000001 || busy !== 1'b0 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_scan[%0d] an=%b seg=%b busy=%b ack=%b want an=%b seg=0000001", j, an, seg, busy, ack, an_pat[j/4]);
            end
        end
    endtask

    task automatic test_load_commit;
        step(4);
        data_in = 16'h12AF;
        load = 1'b1;
        step(1);
        vectors++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL load_busy busy=%b ack=%b want busy=1 ack=0", busy, ack);
        end
        // Load of 0000 held through the wait and the commit cycle must be ignored.
        data_in = 16'h0000;
        for (int j = 0; j < 10; j++) begin
            step(1);
            vectors++;
            if (busy !== 1'b1 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_commit[%0d] busy=%b ack=%b want busy=1 ack=0", j, busy, ack);
            end
        end
        step(1);
        load = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ack !== 1'b1) begin
            miscompares++;
            $display("FAIL commit busy=%b ack=%b want busy=0 ack=1", busy, ack);
        end
        for (int j = 0; j < 16; j++) begin
            step(1);
            vectors++;
            if (an !== an_pat[j/4] || seg !== seg_12af[j/4] || busy !== 1'b0 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL show_12af[%0d] an=%b seg=%b busy=%b ack=%b want an=%b seg=%b", j, an, seg, busy, ack, an_pat[j/4], seg_12af[j/4]);
            end
        end
    endtask

    task automatic test_enable_freeze;
        step(5);
        vectors++;
        if (an !== 4'b1101 || seg !== 7'b0001000) begin
            miscompares++;
            $display("FAIL pre_freeze an=%b seg=%b want an=1101 seg=0001000", an, seg);
        end
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            vectors++;
            if (an !== 4'b1111 || seg !== 7'b1111111) begin
                miscompares++;
                $display("FAIL frozen[%0d] an=%b seg=%b want an=1111 seg=1111111", j, an, seg);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step(1);
            vectors++;
            if (an !== 4'b1101 || seg !== 7'b0001000) begin
                miscompares++;
                $display("FAIL resume[%0d] an=%b seg=%b want an=1101 seg=0001000", j, an, seg);
            end
        end
        step(1);
        vectors++;
        if (an !== 4'b1011 || seg !== 7'b0010010) begin
            miscompares++;
            $display("FAIL resume_next an=%b seg=%b want an=1011 seg=0010010", an, seg);
        end
    endtask

    task automatic test_reset_mid_pending;
        data_in = 16'h5555;
        load = 1'b1;
        step(1);
        load = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_busy busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || ack !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111) begin
            miscompares++;
            $display("FAIL mid_reset busy=%b ack=%b an=%b seg=%b want busy=0 ack=0 an=1111 seg=1111111", busy, ack, an, seg);
        end
        step(2);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step(1);
            vectors++;
            if (an !== an_pat[(j/4)%4] || seg !== 7'b0000001 || busy !== 1'b0 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset[%0d] an=%b seg=%b busy=%b ack=%b want an=%b seg=0000001 busy=0 ack=0", j, an, seg, busy, ack, an_pat[(j/4)%4]);
            end
        end
    endtask

    task automatic test_commit_wait_blank;
        logic [3:0] an2;
        logic [3:0] an3;
        logic [6:0] seg23;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        an2 = 4'b1111;
        an3 = 4'b1111;
        seg23 = 7'b1111111;
`else
        an2 = 4'b1011;
        an3 = 4'b0111;
        seg23 = 7'b0000001;
`endif
        data_in = 16'h0050;
        load = 1'b1;
        step(1);
        load = 1'b0;
        en = 1'b0;
        for (int j = 0; j < 30; j++) begin
            step(1);
            vectors++;
            if (busy !== 1'b1 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_disabled[%0d] busy=%b ack=%b want busy=1 ack=0", j, busy, ack);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step(1);
            vectors++;
            if (busy !== 1'b1 || ack !== 1'b0) begin
                miscompares++;
                $display("FAIL resume_wait[%0d] busy=%b ack=%b want busy=1 ack=0", j, busy, ack);
            end
        end
        step(1);
        vectors++;
        if (busy !== 1'b0 || ack !== 1'b1) begin
            miscompares++;
            $display("FAIL late_commit busy=%b ack=%b want busy=0 ack=1", busy, ack);
        end
        step(1);
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b0000001 || ack !== 1'b0) begin
            miscompares++;
            $display("FAIL d0_0050 an=%b seg=%b ack=%b want an=1110 seg=0000001 ack=0", an, seg, ack);
        end
        step(4);
        vectors++;
        if (an !== 4'b1101 || seg !== 7'b0100100) begin
            miscompares++;
            $display("FAIL d1_0050 an=%b seg=%b want an=1101 seg=0100100", an, seg);
        end
        step(4);
        vectors++;
        if (an !== an2 || seg !== seg23) begin
            miscompares++;
            $display("FAIL d2_0050 an=%b seg=%b want an=%b seg=%b", an, seg, an2, seg23);
        end
        step(4);
        vectors++;
        if (an !== an3 || seg !== seg23) begin
            miscompares++;
            $display("FAIL d3_0050 an=%b seg=%b want an=%b seg=%b", an, seg, an3, seg23);
        end
    endtask

    initial begin
        an_pat[0] = 4'b1110;
        an_pat[1] = 4'b1101;
        an_pat[2] = 4'b1011;
        an_pat[3] = 4'b0111;
        seg_12af[0] = 7'b0111000;
        seg_12af[1] = 7'b0001000;
        seg_12af[2] = 7'b0010010;
        seg_12af[3] = 7'b1001111;

        test_reset();
        test_load_commit();
        test_enable_freeze();
        test_reset_mid_pending();
        test_commit_wait_blank();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
